// File: rtl/ofdm_serializer_pkg.sv
// Shared types for the OFDM serializer/deserializer pair.
package ofdm_serializer_pkg;

  localparam int unsigned SampleW = 16;

  // One complex sample, real part in the upper half.
  typedef struct packed {
    logic signed [SampleW-1:0] r;
    logic signed [SampleW-1:0] i;
  } complex_product_t;

  typedef enum logic {
    StIdle,
    StSend
  } ser_state_e;

  // Width of a counter spanning 'beats' values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ofdm_serializer_if.sv
// Vector-in / two-lane-out stream bundle for the OFDM serializer.
interface ofdm_serializer_if
  import ofdm_serializer_pkg::*;
#(
  parameter int unsigned N = 8
);

  complex_product_t [N-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_ready;
  complex_product_t         data_0;
  complex_product_t         data_1;
  logic                     out_valid;
  logic                     out_last;

  // Producer of vectors / consumer of beats.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, data_0, data_1, out_valid, out_last
  );

  // The serializer itself.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, data_0, data_1, out_valid, out_last
  );

endinterface

// File: rtl/ofdm_serializer_ctrl.sv
// Two-state control for the serializer: tracks the beat index and the handshakes.
module ofdm_serializer_ctrl
  import ofdm_serializer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = cnt_width(N / 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             load_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned      Beats   = N / 2;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Beats - 1);

  ser_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             out_valid_q;
  logic             out_last_q;
  logic             fire;

  // Ready in IDLE, or on the final beat when it is being taken; held low during reset.
  assign in_ready_o = reset & ((state_q == StIdle) |
                               ((state_q == StSend) & out_last_q & out_ready_i));
  assign load_o     = in_valid_i & in_ready_o;
  assign fire       = out_valid_q & out_ready_i;
  assign cnt_inc    = cnt_q + 1'b1;

  // FSM, beat counter and registered valid/last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_o) begin
            state_q     <= StSend;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (LastCnt == '0);
          end
        end
        StSend: begin
          if (fire) begin
            if (out_last_q) begin
              if (load_o) begin
                // Next vector follows without a bubble.
                cnt_q      <= '0;
                out_last_q <= (LastCnt == '0);
              end else begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
            end else begin
              cnt_q      <= cnt_inc;
              out_last_q <= (cnt_inc == LastCnt);
            end
          end
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/ofdm_serializer.sv
// Parallel-to-serial stage: one N-point vector out as N/2 beats of two samples,
// lane 0 carrying element k and lane 1 element k+N/2.
module ofdm_serializer
  import ofdm_serializer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = cnt_width(N / 2)
) (
  input logic               clk,
  input logic               reset,
  ofdm_serializer_if.slave  bus
);

  localparam int unsigned Beats = N / 2;

  complex_product_t [N-1:0] vec_q;
  complex_product_t         data_0;
  complex_product_t         data_1;
  logic                     load;
  logic                     out_valid;
  logic [CNT_W-1:0]         cnt;

  ofdm_serializer_ctrl #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (bus.in_valid),
    .out_ready_i (bus.out_ready),
    .in_ready_o  (bus.in_ready),
    .load_o      (load),
    .out_valid_o (out_valid),
    .out_last_o  (bus.out_last),
    .cnt_o       (cnt)
  );

  // Whole-vector capture on accept; contents only change on a handshake, so stalls are stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_q <= '0;
    end else if (load) begin
      vec_q <= bus.in_data;
    end
  end

  // Two N/2:1 lane muxes; lanes read zero while nothing is being sent.
  always_comb begin
    data_0 = '0;
    data_1 = '0;
    for (int unsigned k = 0; k < Beats; k++) begin
      if (out_valid && (cnt == CNT_W'(k))) begin
        data_0 = vec_q[k];
        data_1 = vec_q[k + Beats];
      end
    end
  end

  assign bus.data_0    = data_0;
  assign bus.data_1    = data_1;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_ofdm_serializer.sv
// Directed bench for ofdm_serializer at N=8 and N=2.
module tb_ofdm_serializer;
  import ofdm_serializer_pkg::*;

  typedef complex_product_t [7:0] vec8_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ofdm_serializer_if #(.N(8)) bus8 ();
  ofdm_serializer_if #(.N(2)) bus2 ();

  ofdm_serializer #(.N(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  ofdm_serializer #(.N(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Bench-side reassembly of the two lanes back into a vector.
  logic  lb_en;
  int    rx_beat;
  vec8_t rx_vec;
  vec8_t rx_q[$];
  vec8_t sent[20];

  always @(negedge clk) begin
    if (lb_en && bus8.out_valid && bus8.out_ready) begin
      rx_vec[rx_beat]     = bus8.data_0;
      rx_vec[rx_beat + 4] = bus8.data_1;
      if (bus8.out_last) begin
        rx_q.push_back(rx_vec);
        rx_beat = 0;
      end else begin
        rx_beat++;
      end
    end
  end

  function automatic complex_product_t cp(input int r, input int i);
    complex_product_t c;
    c.r = 16'(r);
    c.i = 16'(i);
    return c;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec8(input int base);
    for (int j = 0; j < 8; j++) bus8.in_data[j] = cp(base + j, 0);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    lb_en   = 1'b0;
    rx_beat = 0;
    reset   = 1'b0;
    bus8.in_data   = '0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_data   = '0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", bus8.out_valid, 1'b0);
    check("rst_out_last", bus8.out_last, 1'b0);
    check("rst_data_0", bus8.data_0, '0);
    check("rst_data_1", bus8.data_1, '0);
    check("rst_in_ready", bus8.in_ready, 1'b0);
    check("rst_in_ready_n2", bus2.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_in_ready", bus8.in_ready, 1'b1);
    check("idle_out_valid", bus8.out_valid, 1'b0);

    // Single frame r=0..7
    load_vec8(0);
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("f1_valid", bus8.out_valid, 1'b1);
      check("f1_data_0", bus8.data_0, cp(k, 0));
      check("f1_data_1", bus8.data_1, cp(k + 4, 0));
      check("f1_last", bus8.out_last, (k == 3));
      check("f1_in_ready", bus8.in_ready, (k == 3));
      tick();
    end
    check("f1_valid_fall", bus8.out_valid, 1'b0);
    check("f1_last_fall", bus8.out_last, 1'b0);

    // Back-to-back: second vector held valid through frame 1
    load_vec8(0);
    bus8.in_valid = 1'b1;
    tick();
    load_vec8(10);
    for (int k = 0; k < 4; k++) begin
      check("b2b_a_data_0", bus8.data_0, cp(k, 0));
      check("b2b_a_data_1", bus8.data_1, cp(k + 4, 0));
      check("b2b_a_in_ready", bus8.in_ready, (k == 3));
      tick();
    end
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b2b_b_valid", bus8.out_valid, 1'b1);
      check("b2b_b_data_0", bus8.data_0, cp(10 + k, 0));
      check("b2b_b_data_1", bus8.data_1, cp(14 + k, 0));
      check("b2b_b_last", bus8.out_last, (k == 3));
      tick();
    end
    check("b2b_valid_fall", bus8.out_valid, 1'b0);

    // Backpressure at beat 1
    load_vec8(0);
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check("bp_beat0", bus8.data_0, cp(0, 0));
    tick();
    check("bp_beat1_d0", bus8.data_0, cp(1, 0));
    bus8.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp_stall_valid", bus8.out_valid, 1'b1);
      check("bp_stall_d0", bus8.data_0, cp(1, 0));
      check("bp_stall_d1", bus8.data_1, cp(5, 0));
      check("bp_stall_in_ready", bus8.in_ready, 1'b0);
    end
    bus8.out_ready = 1'b1;
    tick();
    check("bp_resume_d0", bus8.data_0, cp(2, 0));
    check("bp_resume_d1", bus8.data_1, cp(6, 0));
    tick();
    check("bp_beat3_d0", bus8.data_0, cp(3, 0));
    check("bp_beat3_last", bus8.out_last, 1'b1);
    tick();
    check("bp_done_valid", bus8.out_valid, 1'b0);

    // Reset between edges after beat 1
    load_vec8(0);
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    check("mr_beat1_d0", bus8.data_0, cp(1, 0));
    #2;
    reset = 1'b0;
    #1;
    check("mr_valid", bus8.out_valid, 1'b0);
    check("mr_d0", bus8.data_0, '0);
    check("mr_d1", bus8.data_1, '0);
    check("mr_last", bus8.out_last, 1'b0);
    check("mr_in_ready", bus8.in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_rel_in_ready", bus8.in_ready, 1'b1);
    check("mr_rel_valid", bus8.out_valid, 1'b0);
    tick();
    check("mr_no_resume", bus8.out_valid, 1'b0);
    load_vec8(0);
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check("mr_new_d0", bus8.data_0, cp(0, 0));
    check("mr_new_d1", bus8.data_1, cp(4, 0));
    repeat (4) tick();
    check("mr_new_done", bus8.out_valid, 1'b0);

    // Loopback: 20 random frames with nonzero imaginary parts
    lb_en   = 1'b1;
    rx_beat = 0;
    for (int f = 0; f < 20; f++) begin
      bit ok;
      for (int j = 0; j < 8; j++) sent[f][j] = cp(int'($urandom_range(0, 65535)),
                                                 int'($urandom_range(0, 65535) | 1));
      if ($urandom_range(0, 3) == 0) begin
        bus8.in_valid = 1'b0;
        tick();
      end
      bus8.in_data  = sent[f];
      bus8.in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        ok = bus8.in_ready;
        tick();
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $error("FAIL lb_accept_timeout: got no accept expected accept for frame %0d", f);
      end
    end
    bus8.in_valid = 1'b0;
    repeat (8) tick();
    lb_en = 1'b0;
    check("lb_frame_count", rx_q.size(), 20);
    for (int f = 0; f < 20 && f < rx_q.size(); f++) check("lb_frame", rx_q[f], sent[f]);

    // N=2 build
    bus2.in_data[0] = cp(3, 0);
    bus2.in_data[1] = cp(9, 0);
    bus2.in_valid   = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    check("n2_valid", bus2.out_valid, 1'b1);
    check("n2_d0", bus2.data_0, cp(3, 0));
    check("n2_d1", bus2.data_1, cp(9, 0));
    check("n2_last", bus2.out_last, 1'b1);
    check("n2_in_ready", bus2.in_ready, 1'b1);
    tick();
    check("n2_valid_fall", bus2.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
